// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte/half/word widths,
// sub-word stores at non-zero offsets done as read-modify-write.
module load_store_unit #(
  parameter int P_ADDR_WIDTH = 11,
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req,
  output logic                    o_ready,
  input  logic                    i_we,
  input  logic [2:0]              i_funct3,
  input  logic [P_ADDR_WIDTH+1:0] i_addr,
  input  logic [P_DATA_WIDTH-1:0] i_wdata,
  output logic [P_DATA_WIDTH-1:0] o_rdata,
  output logic                    o_done,
  output logic                    o_err,
  output logic                    o_mem_we,
  output logic [P_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [1:0]              o_mem_storetype,
  output logic [P_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0] i_mem_rdata
);
  localparam int NUM_LANES = P_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              funct3_q;
  logic [P_ADDR_WIDTH+1:0] addr_q;
  logic [P_DATA_WIDTH-1:0] wdata_q;
  logic [P_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]              st_q;
  logic                    err_q;

  // request classification on the raw inputs, used only at accept
  logic [1:0] size;
  logic       illegal, misalign, direct, bad;

  always_comb begin
    size     = i_funct3[1:0];
    illegal  = i_we ? (i_funct3[2] | (i_funct3[1:0] == 2'b11))
                    : ((i_funct3[1:0] == 2'b11) | (i_funct3[2:1] == 2'b11));
    misalign = ((size == 2'b01) & i_addr[0]) |
               ((size == 2'b10) & (i_addr[1:0] != 2'b00));
    direct   = (size == 2'b10) |
               ((size == 2'b00) & (i_addr[1:0] == 2'b00)) |
               ((size == 2'b01) & ~i_addr[1]);
    bad      = illegal | misalign;
  end

  // load lane select and extension
  logic [7:0]              lane_b;
  logic [15:0]             lane_h;
  logic [P_DATA_WIDTH-1:0] load_ext;

  always_comb begin
    lane_b = i_mem_rdata[8*addr_q[1:0] +: 8];
    lane_h = addr_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_ext = {{(P_DATA_WIDTH-8){lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{(P_DATA_WIDTH-16){lane_h[15]}}, lane_h};
      3'b100:  load_ext = {{(P_DATA_WIDTH-8){1'b0}}, lane_b};
      3'b101:  load_ext = {{(P_DATA_WIDTH-16){1'b0}}, lane_h};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // read-modify-write merge; SH only reaches here at offset 2
  logic [P_DATA_WIDTH-1:0] sb_merge, sh_merge, rmw_word;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign sb_merge[8*g +: 8] = (int'(addr_q[1:0]) == g) ? wdata_q[7:0]
                                                         : i_mem_rdata[8*g +: 8];
  end

  assign sh_merge = {wdata_q[15:0], i_mem_rdata[15:0]};
  assign rmw_word = funct3_q[0] ? sh_merge : sb_merge;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_req) begin
        if (bad)        state_d = RESP;
        else if (!i_we) state_d = LOAD;
        else if (direct) state_d = WRITE;
        else            state_d = RMW_RD;
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      st_q     <= 2'b10;
      err_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && i_req) begin
        funct3_q <= i_funct3;
        addr_q   <= i_addr;
        wdata_q  <= i_wdata;
        err_q    <= bad;
        st_q     <= (i_we & ~bad & direct) ? size : 2'b10;
      end
      if (state_q == LOAD) rdata_q <= load_ext;
      if (state_q == RMW_RD) begin
        wdata_q <= rmw_word;
        st_q    <= 2'b10;
      end
    end
  end

  assign o_ready         = (state_q == IDLE);
  assign o_done          = (state_q == RESP);
  assign o_err           = (state_q == RESP) & err_q;
  // gated by reset so an abort in WRITE never reaches memory
  assign o_mem_we        = (state_q == WRITE) & i_rst_n;
  assign o_mem_addr      = addr_q[P_ADDR_WIDTH+1:2];
  assign o_mem_storetype = st_q;
  assign o_mem_wdata     = wdata_q;
  assign o_rdata         = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Random + directed bench for load_store_unit: byte-level reference model,
// expected responses queued at issue and checked by a monitor on o_done.
module tb_load_store_unit;
  localparam int AW = 11;

  logic          clk = 1'b0, rst_n = 1'b0, req = 1'b0, we = 1'b0;
  logic [2:0]    f3 = '0;
  logic [AW+1:0] addr = '0;
  logic [31:0]   wdata = '0;
  logic          ready, done, err, mem_we;
  logic [31:0]   rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_st;

  always #5 clk = ~clk;

  load_store_unit #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .o_ready(ready),
    .i_we(we), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
    .o_rdata(rdata), .o_done(done), .o_err(err),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_storetype(mem_st),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  // memory that can only write the low byte / low half / full word
  logic [31:0]   mem [0:2047];
  logic          tb_wr = 1'b0;
  logic [AW-1:0] tb_waddr = '0;
  logic [31:0]   tb_wval = '0;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_st)
        2'b00:   mem[mem_addr][7:0]  <= mem_wdata[7:0];
        2'b01:   mem[mem_addr][15:0] <= mem_wdata[15:0];
        2'b10:   mem[mem_addr]       <= mem_wdata;
        default: ;
      endcase
    end else if (tb_wr) begin
      mem[tb_waddr] <= tb_wval;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: byte-addressed memory and last load result
  logic [7:0]  rb [0:255];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] ref_word(input int w);
    return {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]};
  endfunction

  typedef struct {
    int          done_cyc;
    logic        err;
    logic [31:0] rd;
    int          nwr;
    logic [1:0]  st;
    int          widx;
    logic [31:0] word;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      req = 1'($urandom); we = 1'($urandom); f3 = 3'($urandom);
      addr = 13'($urandom); wdata = $urandom;
      @(negedge clk);
      n++;
    end
    req = 1'b0;
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic preload(input int w, input logic [31:0] val);
    wait_ready();
    tb_waddr = AW'(w); tb_wval = val; tb_wr = 1'b1;
    for (int i = 0; i < 4; i++) rb[4*w+i] = val[8*i +: 8];
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic issue(input logic w, input logic [2:0] f, input logic [12:0] a,
                       input logic [31:0] d);
    exp_t        e;
    int          nb, lat;
    logic        legal, rmw;
    logic [31:0] v;
    wait_ready();
    we = w; f3 = f; addr = a; wdata = d; req = 1'b1;
    legal = w ? (f <= 3'd2) : (f != 3'd3 && f != 3'd6 && f != 3'd7);
    nb    = 1 << f[1:0];
    e.err = !legal || (int'(a) % nb != 0);
    e.nwr = 0;
    e.st  = 2'b10;
    if (e.err) begin
      lat = 1;
    end else if (!w) begin
      v = '0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = rb[int'(a)+i];
      if (!f[2] && nb < 4 && v[8*nb-1])
        for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
      last_rd = v;
      lat = 2;
    end else begin
      for (int i = 0; i < nb; i++) rb[int'(a)+i] = d[8*i +: 8];
      rmw   = (nb < 4) && (int'(a) % 4 != 0);
      lat   = rmw ? 3 : 2;
      e.nwr = 1;
      e.st  = rmw ? 2'b10 : (nb == 1 ? 2'b00 : (nb == 2 ? 2'b01 : 2'b10));
    end
    e.rd   = last_rd;
    e.widx = int'(a) / 4;
    e.word = ref_word(e.widx);
    @(posedge clk); #1;
    req = 1'b0;
    e.done_cyc = cyc + lat - 1;
    sbq.push_back(e);
  endtask

  // monitor: counts writes per transaction, checks every completion
  initial begin
    exp_t        e;
    int          wr_cnt = 0;
    logic [1:0]  wr_st = 2'b10;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_cnt = 0;
      end else begin
        if (mem_we) begin wr_cnt++; wr_st = mem_st; end
        if (done) begin
          if (sbq.size() == 0) begin
            chk("spurious_done", 32'(done), 32'd0);
          end else begin
            e = sbq.pop_front();
            chk("latency", 32'(cyc), 32'(e.done_cyc));
            chk("err", 32'(err), 32'(e.err));
            chk("rdata", rdata, e.rd);
            chk("write_count", 32'(wr_cnt), 32'(e.nwr));
            if (e.nwr > 0) chk("storetype", 32'(wr_st), 32'(e.st));
            chk("mem_word", mem[e.widx], e.word);
          end
          wr_cnt = 0;
        end else if (sbq.size() > 0 && cyc > sbq[0].done_cyc) begin
          e = sbq.pop_front();
          chk("done_timeout", 32'(done), 32'd1);
          wr_cnt = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_storetype", 32'(mem_st), 32'd2);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) preload(w, $urandom);

    preload(2, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 13'h008, '0);
    preload(2, 32'h80FF7F01);
    issue(1'b0, 3'b000, 13'h00B, '0);
    issue(1'b0, 3'b100, 13'h00B, '0);
    issue(1'b0, 3'b101, 13'h00A, '0);
    issue(1'b0, 3'b001, 13'h008, '0);
    preload(1, 32'h11223344);
    issue(1'b1, 3'b000, 13'h005, 32'h000000AA);
    preload(1, 32'h11223344);
    issue(1'b1, 3'b001, 13'h004, 32'h0000BEEF);
    issue(1'b0, 3'b010, 13'h006, '0);
    issue(1'b1, 3'b001, 13'h003, $urandom);
    issue(1'b0, 3'b011, 13'h008, '0);

    for (int i = 0; i < 400; i++)
      issue(1'($urandom), 3'($urandom), 13'($urandom_range(0, 63)), $urandom);

    n = 0;
    while (sbq.size() > 0 && n < 50) begin @(negedge clk); n++; end

    // reset during the WRITE cycle of an RMW store
    preload(1, 32'h11223344);
    wait_ready();
    we = 1'b1; f3 = 3'b000; addr = 13'h005; wdata = 32'h000000AA; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("write_cycle_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_suppresses_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_rd = '0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem", mem[1], ref_word(1));

    issue(1'b0, 3'b010, 13'h004, '0);
    n = 0;
    while (sbq.size() > 0 && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
